// File: rtl/loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : loader_pkg                                                 |
// | Description : Shared definitions for the UART ROM loader: the frame      |
// |               sync byte and the loader FSM state encoding.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package loader_pkg;

    // First byte of every load frame; anything else in IDLE is line noise.
    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_LO = 3'd1,
        CNT_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4
    } loader_state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx                                                    |
// | Description : 8N1 UART receiver, LSB first, with input synchronizer,     |
// |               start-bit glitch rejection and stop-bit framing check.     |
// | Ports       : clk, rst (async, active-low), rx_i (async serial in),      |
// |               byte_o (last good byte), byte_valid_o (1-cycle pulse),     |
// |               frame_err_o (1-cycle pulse on stop bit = 0).               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int                  c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0]  c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    logic [1:0]         r_sync;
    logic               r_prev;
    logic               w_rx;

    rx_state_t          r_state,   w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [2:0]         r_bit,     w_bit_nxt;
    logic [7:0]         r_shift,   w_shift_nxt;
    logic [7:0]         r_byte,    w_byte_nxt;
    logic               r_valid,   w_valid_nxt;
    logic               r_ferr,    w_ferr_nxt;

    assign w_rx = r_sync[1];

    // Two-flop synchronizer; r_prev gives a falling-edge detector on the
    // synchronized line so a line held low after a framing error cannot
    // retrigger a frame until it has returned high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], rx_i};
            r_prev <= r_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_byte  <= w_byte_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_byte_nxt  = r_byte;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_prev && !w_rx) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                // Half a bit after the edge: still low means a real start bit.
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_nxt = '0;
                    if (!w_rx) begin
                        w_state_nxt = RX_DATA;
                        w_bit_nxt   = '0;
                    end else begin
                        w_state_nxt = RX_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RX_IDLE;
                    if (w_rx) begin
                        w_byte_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    assign byte_o       = r_byte;
    assign byte_valid_o = r_valid;
    assign frame_err_o  = r_ferr;

endmodule : uart_rx
`default_nettype wire

// File: rtl/uart_rom_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rom_loader                                            |
// | Description : Receives a framed program image over UART and writes it   |
// |               into the instruction ROM, holding the core in reset until  |
// |               a checksum-verified image has been loaded.                 |
// | Ports       : clk, rst (async, active-low), uart_rx_i (serial in),       |
// |               rom_we_o/rom_waddr_o/rom_wdata_o (ROM write port),         |
// |               core_rst_n_o (core reset), loading_o, load_done_o,         |
// |               load_err_o (load status).                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rom_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int ROM_DEPTH    = 4096,
    parameter int ADDR_W       = 12,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_i,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_waddr_o,
    output logic [31:0]       rom_wdata_o,
    output logic              core_rst_n_o,
    output logic              loading_o,
    output logic              load_done_o,
    output logic              load_err_o
);

    localparam int                 c_CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int                 c_TO_CYCLES    = TIMEOUT_BITS * c_CLKS_PER_BIT;
    localparam int                 c_TO_W         = $clog2(c_TO_CYCLES + 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST      = c_TO_W'(c_TO_CYCLES - 1);
    localparam logic [15:0]        c_DEPTH        = 16'(ROM_DEPTH);

    logic [7:0]        w_rx_byte;
    logic              w_rx_valid;
    logic              w_rx_ferr;

    loader_state_t     r_state,      w_state_nxt;
    logic [15:0]       r_count,      w_count_nxt;
    logic [31:0]       r_word,       w_word_nxt;
    logic [1:0]        r_byte_idx,   w_byte_idx_nxt;
    logic [15:0]       r_index,      w_index_nxt;
    logic [7:0]        r_csum,       w_csum_nxt;
    logic [c_TO_W-1:0] r_to_cnt,     w_to_cnt_nxt;
    logic              r_we,         w_we_nxt;
    logic [ADDR_W-1:0] r_waddr,      w_waddr_nxt;
    logic [31:0]       r_wdata,      w_wdata_nxt;
    logic              r_core_rst_n, w_core_rst_n_nxt;
    logic              r_loading,    w_loading_nxt;
    logic              r_done,       w_done_nxt;
    logic              r_err,        w_err_nxt;
    logic              w_abort;
    logic [15:0]       w_n;
    logic [31:0]       w_word_shifted;

    uart_rx #(
        .CLKS_PER_BIT (c_CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (uart_rx_i),
        .byte_o       (w_rx_byte),
        .byte_valid_o (w_rx_valid),
        .frame_err_o  (w_rx_ferr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_word       <= '0;
            r_byte_idx   <= '0;
            r_index      <= '0;
            r_csum       <= '0;
            r_to_cnt     <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_core_rst_n <= 1'b1;
            r_loading    <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_word       <= w_word_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_index      <= w_index_nxt;
            r_csum       <= w_csum_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_we         <= w_we_nxt;
            r_waddr      <= w_waddr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_core_rst_n <= w_core_rst_n_nxt;
            r_loading    <= w_loading_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_word_nxt       = r_word;
        w_byte_idx_nxt   = r_byte_idx;
        w_index_nxt      = r_index;
        w_csum_nxt       = r_csum;
        w_to_cnt_nxt     = r_to_cnt;
        w_we_nxt         = 1'b0;
        w_waddr_nxt      = r_waddr;
        w_wdata_nxt      = r_wdata;
        w_core_rst_n_nxt = r_core_rst_n;
        w_loading_nxt    = r_loading;
        w_done_nxt       = r_done;
        w_err_nxt        = r_err;
        w_abort          = 1'b0;
        w_n              = {w_rx_byte, r_count[7:0]};
        // Bytes arrive LSB first, so each new byte enters at the top and
        // the first byte of a word ends up in bits [7:0].
        w_word_shifted   = {w_rx_byte, r_word[31:8]};

        if (r_state == IDLE) begin
            // Framing errors and non-sync bytes are ignored while idle.
            if (w_rx_valid && (w_rx_byte == c_SYNC_BYTE)) begin
                w_state_nxt      = CNT_LO;
                w_core_rst_n_nxt = 1'b0;
                w_loading_nxt    = 1'b1;
                w_done_nxt       = 1'b0;
                w_err_nxt        = 1'b0;
                w_to_cnt_nxt     = '0;
            end
        end else if (w_rx_ferr) begin
            w_abort = 1'b1;
        end else if (w_rx_valid) begin
            w_to_cnt_nxt = '0;
            case (r_state)
                CNT_LO: begin
                    w_count_nxt = {8'h00, w_rx_byte};
                    w_state_nxt = CNT_HI;
                end
                CNT_HI: begin
                    w_count_nxt = w_n;
                    if (w_n > c_DEPTH) begin
                        w_abort = 1'b1;
                    end else if (w_n == 16'd0) begin
                        w_csum_nxt  = '0;
                        w_state_nxt = CSUM;
                    end else begin
                        w_index_nxt    = '0;
                        w_csum_nxt     = '0;
                        w_byte_idx_nxt = '0;
                        w_state_nxt    = DATA;
                    end
                end
                DATA: begin
                    w_word_nxt     = w_word_shifted;
                    w_csum_nxt     = r_csum + w_rx_byte;
                    w_byte_idx_nxt = r_byte_idx + 1'b1;
                    if (r_byte_idx == 2'd3) begin
                        w_we_nxt    = 1'b1;
                        w_wdata_nxt = w_word_shifted;
                        w_waddr_nxt = r_index[ADDR_W-1:0];
                        w_index_nxt = r_index + 16'd1;
                        if (r_index == r_count - 16'd1) begin
                            w_state_nxt = CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (w_rx_byte == r_csum) begin
                        w_done_nxt       = 1'b1;
                        w_core_rst_n_nxt = 1'b1;
                        w_loading_nxt    = 1'b0;
                        w_state_nxt      = IDLE;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
                default: w_abort = 1'b1;
            endcase
        end else if (r_to_cnt == c_TO_LAST) begin
            w_abort = 1'b1;
        end else begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
        end

        // An abort leaves the core held in reset: the ROM may hold a
        // partial image, so only a later good load may release it.
        if (w_abort) begin
            w_err_nxt     = 1'b1;
            w_loading_nxt = 1'b0;
            w_state_nxt   = IDLE;
        end
    end

    assign rom_we_o     = r_we;
    assign rom_waddr_o  = r_waddr;
    assign rom_wdata_o  = r_wdata;
    assign core_rst_n_o = r_core_rst_n;
    assign loading_o    = r_loading;
    assign load_done_o  = r_done;
    assign load_err_o   = r_err;

endmodule : uart_rom_loader
`default_nettype wire

// File: tb/tb_uart_rom_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rom_loader                                         |
// | Description : Self-checking bench for uart_rom_loader: directed frames   |
// |               plus randomized images checked against a frame-level       |
// |               reference model (byte list, checksum, expected writes).    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rom_loader;

    localparam int c_CPB = 10;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk;
    logic        rst;
    logic        uart_rx;
    logic        rom_we;
    logic [3:0]  rom_waddr;
    logic [31:0] rom_wdata;
    logic        core_rst_n;
    logic        loading;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    logic [3:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          we_double   = 0;
    int          rx_valid_cnt = 0;
    logic        prev_we     = 1'b0;

    uart_rom_loader #(
        .CLK_FREQ     (1_000_000),
        .BAUD         (100_000),
        .ROM_DEPTH    (16),
        .ADDR_W       (4),
        .TIMEOUT_BITS (40)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx_i    (uart_rx),
        .rom_we_o     (rom_we),
        .rom_waddr_o  (rom_waddr),
        .rom_wdata_o  (rom_wdata),
        .core_rst_n_o (core_rst_n),
        .loading_o    (loading),
        .load_done_o  (load_done),
        .load_err_o   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (rom_we) begin
                wa_q.push_back(rom_waddr);
                wd_q.push_back(rom_wdata);
            end
            if (rom_we && prev_we) we_double++;
            prev_we = rom_we;
            if (dut.u_rx.byte_valid_o) rx_valid_cnt++;
        end else begin
            prev_we = 1'b0;
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (c_CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (c_CPB) @(posedge clk);
        end
        uart_rx = stop_bit;
        repeat (c_CPB) @(posedge clk);
        uart_rx = 1'b1;
    endtask

    // Reference frame: sync, 16-bit LE count, LE words, sum-of-data checksum.
    function automatic bq_t build_frame(input wq_t w, input logic bad);
        bq_t q;
        int  sum = 0;
        q.push_back(8'hA5);
        q.push_back(8'(w.size() % 256));
        q.push_back(8'(w.size() / 256));
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) begin
                q.push_back(8'((w[i] >> (8 * k)) % 256));
                sum += int'((w[i] >> (8 * k)) % 256);
            end
        end
        q.push_back(8'((sum + (bad ? 1 : 0)) % 256));
        return q;
    endfunction

    task automatic check_writes(input string tag, input wq_t exp);
        chk({tag, "_nwr"}, 32'(wd_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wd_q.size(); i++) begin
            chk({tag, "_addr"}, 32'(wa_q[i]), 32'(i));
            chk({tag, "_data"}, wd_q[i], exp[i]);
        end
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic run_load(input string tag, input wq_t w, input logic bad);
        bq_t q;
        q = build_frame(w, bad);
        send_byte(q[0], 1'b1);
        repeat (2) @(negedge clk);
        chk({tag, "_core_held"}, 32'(core_rst_n), 32'd0);
        chk({tag, "_loading"}, 32'(loading), 32'd1);
        for (int i = 1; i < q.size(); i++) send_byte(q[i], 1'b1);
        repeat (3) @(negedge clk);
        check_writes(tag, w);
        chk({tag, "_done"}, 32'(load_done), bad ? 32'd0 : 32'd1);
        chk({tag, "_err"}, 32'(load_err), bad ? 32'd1 : 32'd0);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), bad ? 32'd0 : 32'd1);
        chk({tag, "_loading_end"}, 32'(loading), 32'd0);
    endtask

    initial begin
        wq_t w;
        wq_t none;
        int  base;

        rst     = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(rom_we), 32'd0);
        chk("rst_waddr", 32'(rom_waddr), 32'd0);
        chk("rst_wdata", rom_wdata, 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd1);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Good load from the reference program.
        w = '{32'h0000_0013, 32'h00A0_0093};
        run_load("good", w, 1'b0);

        // Same image with checksum 0x47, then recovery.
        run_load("badcsum", w, 1'b1);
        run_load("recover", w, 1'b0);

        // Oversize count N = 17 aborts before any data.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (3) @(negedge clk);
        check_writes("oversize", none);
        chk("oversize_err", 32'(load_err), 32'd1);
        chk("oversize_loading", 32'(loading), 32'd0);
        chk("oversize_core", 32'(core_rst_n), 32'd0);

        // Empty image.
        run_load("empty", none, 1'b0);

        // Short low pulse in IDLE must not produce a byte.
        base = rx_valid_cnt;
        uart_rx = 1'b0;
        repeat (3) @(posedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_bytes", 32'(rx_valid_cnt - base), 32'd0);
        chk("glitch_loading", 32'(loading), 32'd0);

        // Stop bit of 0 in the middle of DATA.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (3) @(negedge clk);
        chk("ferr_err", 32'(load_err), 32'd1);
        chk("ferr_loading", 32'(loading), 32'd0);
        chk("ferr_core", 32'(core_rst_n), 32'd0);
        check_writes("ferr", none);
        repeat (20) @(negedge clk);

        // Inter-byte timeout.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        repeat (300) @(negedge clk);
        chk("to_still_loading", 32'(loading), 32'd1);
        chk("to_err_early", 32'(load_err), 32'd0);
        repeat (120) @(negedge clk);
        chk("to_err", 32'(load_err), 32'd1);
        chk("to_loading", 32'(loading), 32'd0);
        chk("to_core", 32'(core_rst_n), 32'd0);
        check_writes("to", none);

        // Randomized images against the frame model.
        for (int f = 0; f < 4; f++) begin
            int n;
            n = $urandom_range(1, 6);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            run_load($sformatf("rand%0d", f), w, ($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset in the middle of DATA.
        w = '{$urandom};
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int k = 0; k < 4; k++) send_byte(8'((w[0] >> (8 * k)) % 256), 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b1);
        repeat (2) @(negedge clk);
        check_writes("pre_rst", w);
        chk("pre_rst_core", 32'(core_rst_n), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_we", 32'(rom_we), 32'd0);
        chk("arst_waddr", 32'(rom_waddr), 32'd0);
        chk("arst_wdata", rom_wdata, 32'd0);
        chk("arst_core_rst_n", 32'(core_rst_n), 32'd1);
        chk("arst_loading", 32'(loading), 32'd0);
        chk("arst_done", 32'(load_done), 32'd0);
        chk("arst_err", 32'(load_err), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        chk("we_single_cycle", 32'(we_double), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rom_loader
`default_nettype wire
